fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Instruction-fetch stage that sits directly upstream of decode and the immediate-extend logic.
- Owns the PC register and issues word-aligned requests to instruction memory with a ready handshake.
- Buffers returned words, with their PC, in a small FIFO that is presented to decode through a valid/ready interface.
- Accepts a branch redirect (target from the branch adder fed by the extended imm24<<2), which flushes the FIFO and restarts fetch at the target.

Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch address after reset, word-aligned.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, bits[1:0]=0.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word, valid when imem_req&&imem_ready.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes the head.
- inst_out  out  32  head instruction; decode drives Instr[23:0] to extend from it.
- inst_pc  out  32  address of the head instruction.
- inst_pc8  out  32  inst_pc+8 (ARM PC read value), modulo 2^32.
- redirect  in  1  branch taken; flush and refetch.
- redirect_target  in  32  new fetch address; bits[1:0] ignored (forced 0).

Behaviour:
- Clock and reset: one clock domain. reset_n low asynchronously clears all state:
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0.
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc8=0 while reset_n is low.
  - Reset mid-operation discards all buffered entries and any in-progress request; nothing is pushed after reset.
- Internal state: fetch_pc, wr_ptr, rd_ptr, count (0..DEPTH, log2(DEPTH)+1 bits). Fetch state machine:
  - RUN: count<DEPTH; imem_req=1, imem_addr=fetch_pc.
  - FULL: count==DEPTH; imem_req=0.
  - Transitions are evaluated on next_count. RUN→FULL when next_count==DEPTH. FULL→RUN when next_count<DEPTH.
  - Redirect forces RUN.
- Handshake, memory side:
  - Request accepted when imem_req&&imem_ready&&!redirect → push {fetch_pc, imem_rdata}, fetch_pc+=4 (wraps 32'hFFFF_FFFC→0).
  - While imem_ready=0, imem_req and imem_addr stay stable.
  - Push never occurs with count==DEPTH, because imem_req=0 in FULL. A pop in FULL does not enable a same-cycle push; request resumes the next cycle.
- Handshake, decode side:
  - inst_valid=(count!=0). inst_out, inst_pc, inst_pc8 come from the entry at rd_ptr.
  - inst_out, inst_pc, inst_pc8 are 0 when count==0.
  - Pop when inst_valid&&inst_ready&&!redirect.
  - Head outputs stay stable while inst_valid&&!inst_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Redirect has priority over push and pop in the same cycle:
  - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_target[31:2],2'b00}.
  - imem_rdata accepted in the redirect cycle is dropped.
  - Decode may still see inst_valid in the redirect cycle, but a handshake in that cycle is not a pop.
  - Back-to-back redirects: the last one wins.
- Latency, with imem_ready=1:
  - Reset release at edge E → imem_req=1 with addr RESET_PC before E+1.
  - First inst_valid after E+1.
  - Redirect at cycle n → imem_addr=target in n+1, inst_valid with the target word in n+2.
- Throughput: one instruction per cycle sustained when imem_ready=1 and inst_ready=1.

Test Plan:
- Reset, imem_ready=1, inst_ready=1, memory returns the address as data → imem_addr sequence 0,4,8,C. inst_out/inst_pc pairs (0,0),(4,4),(8,8). inst_pc8 = inst_pc+8.
- inst_ready=0 for 10 cycles with DEPTH=4 → exactly 4 pushes, then imem_req=0. Release inst_ready → 0,4,8,C delivered in order, and fetching resumes at 0x10.
- imem_ready toggles 1,0,0,1 → imem_addr holds 0x4 through the stall. No duplicate or missing entries.
- 3 entries buffered, redirect with target 0x0000_1003 → next cycle inst_valid=0 and imem_addr=0x1000. Two cycles later inst_pc=0x1000. Stale words are never delivered.
- Redirect in the same cycle as imem_ready=1 and inst_ready=1 → no push, no pop. count=0 next cycle.
- Redirect to 0xFFFF_FFF8 → fetches FFF8, FFFC, 0x0. inst_pc8 for FFF8 = 0x0000_0000.
- reset_n asserted low asynchronously mid-burst with the FIFO full → all outputs 0 immediately. After release, fetch restarts at RESET_PC with no old entries visible.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, decode and the branch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_queue_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc8;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc8,
    input  imem_ready, imem_rdata, inst_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc8,
    output imem_ready, imem_rdata, inst_ready, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, fetches words from instruction memory into a small
// FIFO of {pc, word} entries for decode, and restarts at a branch target on redirect.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset_n,
  fetch_queue_unit_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] CountFull = DEPTH[PtrW:0];

  typedef enum logic [0:0] {StRun, StFull} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic [31:0] word_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  logic push, pop;

  // Gated by reset_n so the request drops the instant reset asserts.
  assign bus.imem_req  = reset_n && (state_q == StRun);
  assign bus.imem_addr = fetch_pc_q;

  assign push = bus.imem_req && bus.imem_ready && !bus.redirect;
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect;

  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = bus.inst_valid ? word_mem_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = bus.inst_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc8   = bus.inst_valid ? pc_mem_q[rd_ptr_q] + 32'd8 : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_target[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      state_d    = StRun;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      state_d = (count_d == CountFull) ? StFull : StRun;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based model of the fetch stream.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic clk = 1'b0;
  logic reset_n;

  fetch_queue_unit_if bus ();

  fetch_queue_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  entry_t      model_q[$];
  logic [31:0] model_pc;
  int          checks = 0;
  int          errors = 0;

  // Memory contents: distinct from the address so word and pc paths are told apart.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hE1A0_5000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic exp_req;
    exp_req = (model_q.size() < DEPTH);
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", bus.imem_addr, model_pc);
    check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      check("inst_out", bus.inst_out, model_q[0].word);
      check("inst_pc", bus.inst_pc, model_q[0].pc);
      check("inst_pc8", bus.inst_pc8, model_q[0].pc + 32'd8);
    end else begin
      check("inst_out_empty", bus.inst_out, 32'h0);
      check("inst_pc_empty", bus.inst_pc, 32'h0);
      check("inst_pc8_empty", bus.inst_pc8, 32'h0);
    end
  endtask

  // One clock: check outputs at negedge, drive inputs, then advance the model at posedge.
  task automatic step(input logic mem_rdy, input logic dec_rdy, input logic redir,
                      input logic [31:0] tgt);
    logic exp_req;
    @(negedge clk);
    compare_outputs();
    bus.imem_ready      = mem_rdy;
    bus.imem_rdata      = mem_rdy ? mem_word(model_pc) : 32'hDEAD_BEEF;
    bus.inst_ready      = dec_rdy;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    @(posedge clk);
    exp_req = (model_q.size() < DEPTH);
    if (redir) begin
      model_q.delete();
      model_pc = {tgt[31:2], 2'b00};
    end else begin
      if (model_q.size() != 0 && dec_rdy) void'(model_q.pop_front());
      if (exp_req && mem_rdy) begin
        model_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.imem_ready      = 1'b0;
    bus.imem_rdata      = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, bus.imem_req}, 32'h0);
    check({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'h0);
    check({tag, "_out"}, bus.inst_out, 32'h0);
    check({tag, "_pc"}, bus.inst_pc, 32'h0);
    check({tag, "_pc8"}, bus.inst_pc8, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    int          guard;
    reset_n = 1'b0;
    idle_inputs();
    model_pc = RESET_PC;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming with both sides ready.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalls long enough to fill the queue, then drains.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Memory stall holds the request.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Buffer three entries, then redirect with both handshakes active.
    guard = 0;
    while (model_q.size() < 3 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    step(1'b1, 1'b1, 1'b1, 32'h0000_1003);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect near the top of the address space to exercise PC wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirects: the last one wins.
    step(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3004);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else tgt = $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), tgt);
    end

    // Asynchronous reset mid-burst with the queue full.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("async_reset");
    model_q.delete();
    model_pc = RESET_PC;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
